// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-port request arbiter driving one asynchronous SRAM access at a time
module mem_arbiter #(
  parameter int N_PORTS     = 2,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int RR_MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_valid,
  input  logic [N_PORTS-1:0]        req_write,
  input  logic [N_PORTS-1:0]        req_byte,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS*32-1:0]     req_wdata,
  output logic [N_PORTS-1:0]        req_ready,
  output logic [N_PORTS-1:0]        rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      sram_sel,
  output logic [19:0]               sram_addr,
  output logic [31:0]               sram_wdata,
  input  logic [31:0]               sram_rdata,
  output logic                      sram_data_oe,
  output logic [3:0]                sram_be_n,
  output logic                      sram_ce_n,
  output logic                      sram_oe_n,
  output logic                      sram_we_n
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cur_port;
  logic             cur_byte;
  logic [1:0]       cur_lane;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]      sel_wdata;
  logic             sel_write;
  logic             sel_byte;
  logic [7:0]       lane_byte;
  logic             unused_addr;

  // Iterate from lowest to highest priority so the last hit is the winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (RR_MODE != 0) begin
      for (int k = N_PORTS; k >= 1; k--) begin
        cand = IDX_W'((int'(last_grant) + k) % N_PORTS);
        if (req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end else begin
      for (int i = N_PORTS - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      req_ready[i] = (state == IDLE) && grant_found && (grant_idx == IDX_W'(i));
    end
  end

  assign sel_addr    = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata   = req_wdata[int'(grant_idx)*32 +: 32];
  assign sel_write   = req_write[grant_idx];
  assign sel_byte    = req_byte[grant_idx];
  assign lane_byte   = sram_rdata[int'(cur_lane)*8 +: 8];
  assign unused_addr = ^sel_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant   <= IDX_W'(N_PORTS - 1);
      cur_port     <= '0;
      cur_byte     <= 1'b0;
      cur_lane     <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      sram_sel     <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      sram_data_oe <= 1'b0;
      sram_be_n    <= 4'b1111;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= '0;
          if (grant_found) begin
            state        <= ACCESS;
            cnt          <= '0;
            last_grant   <= grant_idx;
            cur_port     <= grant_idx;
            cur_byte     <= sel_byte;
            cur_lane     <= sel_addr[1:0];
            sram_sel     <= sel_addr[22];
            sram_addr    <= sel_addr[21:2];
            sram_wdata   <= sel_byte ? {4{sel_wdata[7:0]}} : sel_wdata;
            sram_be_n    <= sel_byte ? ~(4'b0001 << sel_addr[1:0]) : 4'b0000;
            sram_ce_n    <= 1'b0;
            sram_oe_n    <= sel_write;
            sram_we_n    <= ~sel_write;
            sram_data_oe <= sel_write;
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(WAIT_CYCLES - 1)) begin
            state        <= RESP;
            rsp_valid    <= N_PORTS'(1) << cur_port;
            rsp_rdata    <= cur_byte ? {24'b0, lane_byte} : sram_rdata;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_data_oe <= 1'b0;
            sram_be_n    <= 4'b1111;
          end else if (cnt == 4'(WAIT_CYCLES - 2)) begin
            // Final ACCESS cycle is write recovery: data and address still driven.
            sram_we_n <= 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Fixed-priority instance: N_PORTS=3, WAIT_CYCLES=2
  logic [2:0]  f_req_valid, f_req_write, f_req_byte, f_req_ready, f_rsp_valid;
  logic [95:0] f_req_addr, f_req_wdata;
  logic [31:0] f_rsp_rdata, f_sram_wdata, f_sram_rdata, f_mask;
  logic        f_sram_sel, f_sram_data_oe, f_sram_ce_n, f_sram_oe_n, f_sram_we_n;
  logic [19:0] f_sram_addr;
  logic [3:0]  f_sram_be_n;

  // Round-robin instance: N_PORTS=3, WAIT_CYCLES=4
  logic [2:0]  r_req_valid, r_req_write, r_req_byte, r_req_ready, r_rsp_valid;
  logic [95:0] r_req_addr, r_req_wdata;
  logic [31:0] r_rsp_rdata, r_sram_wdata, r_sram_rdata, r_mask;
  logic        r_sram_sel, r_sram_data_oe, r_sram_ce_n, r_sram_oe_n, r_sram_we_n;
  logic [19:0] r_sram_addr;
  logic [3:0]  r_sram_be_n;

  logic [31:0] fmem [0:255];
  logic [31:0] rmem [0:255];
  logic        f_pre_we;
  logic [7:0]  f_pre_idx;
  logic [31:0] f_pre_data;

  mem_arbiter #(.N_PORTS(3), .ADDR_W(32), .WAIT_CYCLES(2), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst),
    .req_valid(f_req_valid), .req_write(f_req_write), .req_byte(f_req_byte),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata), .req_ready(f_req_ready),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata),
    .sram_sel(f_sram_sel), .sram_addr(f_sram_addr), .sram_wdata(f_sram_wdata),
    .sram_rdata(f_sram_rdata), .sram_data_oe(f_sram_data_oe), .sram_be_n(f_sram_be_n),
    .sram_ce_n(f_sram_ce_n), .sram_oe_n(f_sram_oe_n), .sram_we_n(f_sram_we_n)
  );

  mem_arbiter #(.N_PORTS(3), .ADDR_W(32), .WAIT_CYCLES(4), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst),
    .req_valid(r_req_valid), .req_write(r_req_write), .req_byte(r_req_byte),
    .req_addr(r_req_addr), .req_wdata(r_req_wdata), .req_ready(r_req_ready),
    .rsp_valid(r_rsp_valid), .rsp_rdata(r_rsp_rdata),
    .sram_sel(r_sram_sel), .sram_addr(r_sram_addr), .sram_wdata(r_sram_wdata),
    .sram_rdata(r_sram_rdata), .sram_data_oe(r_sram_data_oe), .sram_be_n(r_sram_be_n),
    .sram_ce_n(r_sram_ce_n), .sram_oe_n(r_sram_oe_n), .sram_we_n(r_sram_we_n)
  );

  // SRAM models: byte-masked write while ce_n and we_n are low, combinational read.
  assign f_mask = {{8{~f_sram_be_n[3]}}, {8{~f_sram_be_n[2]}}, {8{~f_sram_be_n[1]}}, {8{~f_sram_be_n[0]}}};
  assign r_mask = {{8{~r_sram_be_n[3]}}, {8{~r_sram_be_n[2]}}, {8{~r_sram_be_n[1]}}, {8{~r_sram_be_n[0]}}};
  assign f_sram_rdata = f_sram_oe_n ? 32'h0 : fmem[{f_sram_sel, f_sram_addr[6:0]}];
  assign r_sram_rdata = r_sram_oe_n ? 32'h0 : rmem[{r_sram_sel, r_sram_addr[6:0]}];

  always @(posedge clk) begin
    if (f_pre_we)
      fmem[f_pre_idx] <= f_pre_data;
    else if (!f_sram_ce_n && !f_sram_we_n)
      fmem[{f_sram_sel, f_sram_addr[6:0]}] <=
        (fmem[{f_sram_sel, f_sram_addr[6:0]}] & ~f_mask) | (f_sram_wdata & f_mask);
  end

  always @(posedge clk) begin
    if (!r_sram_ce_n && !r_sram_we_n)
      rmem[{r_sram_sel, r_sram_addr[6:0]}] <=
        (rmem[{r_sram_sel, r_sram_addr[6:0]}] & ~r_mask) | (r_sram_wdata & r_mask);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    f_pre_we = 1'b1; f_pre_idx = idx; f_pre_data = data;
    tick();
    f_pre_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    f_req_valid = '0; f_req_write = '0; f_req_byte = '0; f_req_addr = '0; f_req_wdata = '0;
    r_req_valid = '0; r_req_write = '0; r_req_byte = '0; r_req_addr = '0; r_req_wdata = '0;
    f_pre_we = 1'b0; f_pre_idx = '0; f_pre_data = '0;
    repeat (2) tick();
    checks++;
    if ({f_req_ready, f_rsp_valid, f_rsp_rdata} !== 38'h0) begin
      fails++; $display("FAIL reset_rsp: got %h expected 0", {f_req_ready, f_rsp_valid, f_rsp_rdata});
    end
    checks++;
    if ({f_sram_ce_n, f_sram_oe_n, f_sram_we_n, f_sram_be_n, f_sram_data_oe} !== 8'b1111_1110) begin
      fails++; $display("FAIL reset_strobes: got %b expected 11111110",
                        {f_sram_ce_n, f_sram_oe_n, f_sram_we_n, f_sram_be_n, f_sram_data_oe});
    end
    checks++;
    if ({f_sram_sel, f_sram_addr, f_sram_wdata} !== 53'h0) begin
      fails++; $display("FAIL reset_addr_data: got %h expected 0", {f_sram_sel, f_sram_addr, f_sram_wdata});
    end
    checks++;
    if ({r_sram_ce_n, r_sram_oe_n, r_sram_we_n, r_sram_be_n, r_sram_data_oe, r_rsp_valid} !== 11'b1111_1110_000) begin
      fails++; $display("FAIL reset_rr_outputs: got %b expected 11111110000",
                        {r_sram_ce_n, r_sram_oe_n, r_sram_we_n, r_sram_be_n, r_sram_data_oe, r_rsp_valid});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin;
    int got[$];
    int exp_order [9] = '{0, 1, 2, 0, 1, 2, 0, 2, 0};
    r_req_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    r_req_valid = 3'b111;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (r_req_ready[i]) got.push_back(i);
    end
    r_req_valid = 3'b101;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (r_req_ready[i]) got.push_back(i);
    end
    r_req_valid = '0;
    repeat (8) tick();
    checks++;
    if (got.size() != 9) begin
      fails++; $display("FAIL rr_grant_count: got %0d expected 9", got.size());
    end
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      checks++;
      if (got[i] != exp_order[i]) begin
        fails++; $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, got[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_word_read;
    preload(8'h04, 32'hDEAD_BEEF);
    f_req_addr[32 +: 32] = 32'h0000_0010;
    f_req_write = '0; f_req_byte = '0;
    f_req_valid = 3'b010;
    #1;
    checks++;
    if (f_req_ready !== 3'b010) begin
      fails++; $display("FAIL read_accept: got %b expected 010", f_req_ready);
    end
    tick();
    f_req_valid = '0;
    checks++;
    if ({f_sram_ce_n, f_sram_oe_n, f_sram_we_n, f_sram_data_oe, f_sram_be_n, f_sram_addr} !== {4'b0010, 4'b0000, 20'h00004}) begin
      fails++; $display("FAIL read_access1: got %h expected %h",
                        {f_sram_ce_n, f_sram_oe_n, f_sram_we_n, f_sram_data_oe, f_sram_be_n, f_sram_addr},
                        {4'b0010, 4'b0000, 20'h00004});
    end
    tick();
    checks++;
    if ({f_sram_ce_n, f_sram_oe_n, f_rsp_valid} !== 5'b00_000) begin
      fails++; $display("FAIL read_access2: got %b expected 00000", {f_sram_ce_n, f_sram_oe_n, f_rsp_valid});
    end
    tick();
    checks++;
    if ({f_rsp_valid, f_rsp_rdata, f_sram_ce_n, f_sram_oe_n} !== {3'b010, 32'hDEAD_BEEF, 2'b11}) begin
      fails++; $display("FAIL read_resp: got valid=%b data=%h ce_n=%b oe_n=%b expected valid=010 data=deadbeef ce_n=1 oe_n=1",
                        f_rsp_valid, f_rsp_rdata, f_sram_ce_n, f_sram_oe_n);
    end
    tick();
    checks++;
    if (f_rsp_valid !== 3'b000) begin
      fails++; $display("FAIL read_resp_pulse: got %b expected 000", f_rsp_valid);
    end
  endtask

  task automatic test_byte_write_read;
    preload(8'h80, 32'h1122_3344);
    f_req_addr[0 +: 32]  = 32'h0040_0003;
    f_req_wdata[0 +: 32] = 32'hAABB_CC5A;
    f_req_write = 3'b001; f_req_byte = 3'b001;
    f_req_valid = 3'b001;
    #1;
    checks++;
    if (f_req_ready !== 3'b001) begin
      fails++; $display("FAIL bw_accept: got %b expected 001", f_req_ready);
    end
    tick();
    f_req_valid = '0;
    checks++;
    if ({f_sram_sel, f_sram_be_n, f_sram_wdata, f_sram_addr} !== {1'b1, 4'b0111, 32'h5A5A_5A5A, 20'h0}) begin
      fails++; $display("FAIL bw_lanes: got sel=%b be_n=%b wdata=%h addr=%h expected sel=1 be_n=0111 wdata=5a5a5a5a addr=00000",
                        f_sram_sel, f_sram_be_n, f_sram_wdata, f_sram_addr);
    end
    checks++;
    if ({f_sram_ce_n, f_sram_we_n, f_sram_oe_n, f_sram_data_oe} !== 4'b0011) begin
      fails++; $display("FAIL bw_strobe1: got %b expected 0011", {f_sram_ce_n, f_sram_we_n, f_sram_oe_n, f_sram_data_oe});
    end
    tick();
    checks++;
    if ({f_sram_ce_n, f_sram_we_n, f_sram_data_oe, f_sram_wdata} !== {3'b011, 32'h5A5A_5A5A}) begin
      fails++; $display("FAIL bw_recovery: got %h expected %h", {f_sram_ce_n, f_sram_we_n, f_sram_data_oe, f_sram_wdata},
                        {3'b011, 32'h5A5A_5A5A});
    end
    tick();
    checks++;
    if ({f_rsp_valid, f_sram_ce_n, f_sram_data_oe} !== 5'b001_10) begin
      fails++; $display("FAIL bw_resp: got %b expected 00110", {f_rsp_valid, f_sram_ce_n, f_sram_data_oe});
    end
    tick();
    f_req_write = '0;
    f_req_valid = 3'b001;
    tick();
    f_req_valid = '0;
    checks++;
    if ({f_sram_be_n, f_sram_oe_n} !== 5'b0111_0) begin
      fails++; $display("FAIL br_access: got %b expected 01110", {f_sram_be_n, f_sram_oe_n});
    end
    repeat (2) tick();
    checks++;
    if ({f_rsp_valid, f_rsp_rdata} !== {3'b001, 32'h0000_005A}) begin
      fails++; $display("FAIL br_data: got valid=%b data=%h expected valid=001 data=0000005a", f_rsp_valid, f_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_fixed_priority;
    int g0 = 0;
    int g12 = 0;
    f_req_addr  = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
    f_req_write = '0; f_req_byte = '0;
    f_req_valid = 3'b111;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (f_req_ready[0]) g0++;
      if (f_req_ready[1] || f_req_ready[2]) g12++;
    end
    f_req_valid = 3'b110;
    tick();
    checks++;
    if (g0 != 3 || g12 != 0) begin
      fails++; $display("FAIL fixed_grants: got port0=%0d others=%0d expected port0=3 others=0", g0, g12);
    end
    checks++;
    if (f_req_ready !== 3'b010) begin
      fails++; $display("FAIL fixed_next: got %b expected 010", f_req_ready);
    end
    f_req_valid = '0;
    repeat (5) tick();
  endtask

  task automatic test_back_to_back;
    r_req_addr[0 +: 32]  = 32'h0000_0020;
    r_req_wdata[0 +: 32] = 32'h1234_5678;
    r_req_write = 3'b001; r_req_byte = '0;
    r_req_valid = 3'b001;
    #1;
    checks++;
    if (r_req_ready !== 3'b001) begin
      fails++; $display("FAIL b2b_write_accept: got %b expected 001", r_req_ready);
    end
    tick();
    r_req_write = '0;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (r_req_ready !== 3'b000) begin
        fails++; $display("FAIL b2b_early_accept: cycle %0d got %b expected 000", c, r_req_ready);
      end
      if (c == 4) begin
        checks++;
        if ({r_sram_ce_n, r_sram_we_n, r_sram_data_oe} !== 3'b011) begin
          fails++; $display("FAIL b2b_write_recovery: got %b expected 011", {r_sram_ce_n, r_sram_we_n, r_sram_data_oe});
        end
      end
      if (c == 5) begin
        checks++;
        if (r_rsp_valid !== 3'b001) begin
          fails++; $display("FAIL b2b_write_resp: got %b expected 001", r_rsp_valid);
        end
      end
      tick();
    end
    checks++;
    if (r_req_ready !== 3'b001) begin
      fails++; $display("FAIL b2b_read_accept: got %b expected 001", r_req_ready);
    end
    tick();
    r_req_valid = '0;
    repeat (4) tick();
    checks++;
    if ({r_rsp_valid, r_rsp_rdata} !== {3'b001, 32'h1234_5678}) begin
      fails++; $display("FAIL b2b_read_data: got valid=%b data=%h expected valid=001 data=12345678", r_rsp_valid, r_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_access;
    f_req_addr[0 +: 32]  = 32'h0000_0030;
    f_req_wdata[0 +: 32] = 32'hCAFE_F00D;
    f_req_write = 3'b001; f_req_byte = '0;
    f_req_valid = 3'b001;
    tick();
    f_req_valid = '0;
    tick();
    checks++;
    if ({f_sram_ce_n, f_sram_data_oe} !== 2'b01) begin
      fails++; $display("FAIL rst_pre_active: got %b expected 01", {f_sram_ce_n, f_sram_data_oe});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({f_sram_ce_n, f_sram_oe_n, f_sram_we_n, f_sram_data_oe, f_sram_be_n} !== 8'b1110_1111) begin
      fails++; $display("FAIL rst_async_strobes: got %b expected 11101111",
                        {f_sram_ce_n, f_sram_oe_n, f_sram_we_n, f_sram_data_oe, f_sram_be_n});
    end
    #2;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({f_rsp_valid, f_sram_ce_n} !== 4'b000_1) begin
        fails++; $display("FAIL rst_no_resp: cycle %0d got %b expected 0001", c, {f_rsp_valid, f_sram_ce_n});
      end
    end
    tick();
    f_req_write = '0;
    f_req_valid = 3'b100;
    #1;
    checks++;
    if (f_req_ready !== 3'b100) begin
      fails++; $display("FAIL rst_first_accept: got %b expected 100", f_req_ready);
    end
    tick();
    f_req_valid = '0;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_word_read();
    test_byte_write_read();
    test_fixed_priority();
    test_back_to_back();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
